// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
// master = the receiver, slave = the consumer (register block or bench).
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (input rx, output data_out, output valid, output frame_err, output busy);
    modport slave  (output rx, input data_out, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, bit-midpoint sampling; valid/frame_err appear 2+HALF_BIT+9*CLKS_PER_BIT+1 cycles after the rx fall.
// No backpressure: each byte is strobed for exactly one cycle and the consumer must take it then.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [1:0]    sync_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          busy_q;
    logic          rx_s;
    logic          half_pt;
    logic          full_pt;

    assign rx_s    = sync_q[1];
    assign half_pt = (cnt_q == HALF_M1);
    assign full_pt = (cnt_q == FULL_M1);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sync_q  <= 2'b11;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (half_pt) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DATA: begin
                    if (full_pt) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_STOP: begin
                    if (full_pt) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                // A held-low line must go high before another start can be detected.
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: ideal-timing serial stimulus, expected bytes and strobe cycles from frame arithmetic.
module tb_uart_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rx_a;
    logic rx_b;

    uart_rx_if ifa();
    uart_rx_if ifb();
    assign ifa.rx = rx_a;
    assign ifb.rx = rx_b;

    uart_rx #(.CLKS_PER_BIT(8))   dut_a (.clk(clk), .rst(rst), .bus(ifa));
    uart_rx #(.CLKS_PER_BIT(868)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         va_cyc[$];
    logic [7:0] va_dat[$];
    int         fa_cyc[$];
    int         vb_cyc[$];
    logic [7:0] vb_dat[$];
    int         fb_cnt = 0;
    int         both_hi = 0;
    logic       busy_a[int];

    always @(negedge clk) begin
        if (ifa.valid === 1'b1) begin
            va_cyc.push_back(cyc);
            va_dat.push_back(ifa.data_out);
        end
        if (ifa.frame_err === 1'b1) fa_cyc.push_back(cyc);
        if (ifa.valid === 1'b1 && ifa.frame_err === 1'b1) both_hi++;
        if (ifb.valid === 1'b1) begin
            vb_cyc.push_back(cyc);
            vb_dat.push_back(ifb.data_out);
        end
        if (ifb.frame_err === 1'b1) fb_cnt++;
        busy_a[cyc] = ifa.busy;
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_good = 8'h00;

    // Strobe delay from rx fall: 2 sync stages, half bit, 9 full bits, 1 register stage.
    function automatic int lat(input int cpb);
        return 2 + cpb / 2 + 9 * cpb + 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts driving immediately; k0 is the cycle of the start-bit falling edge.
    task automatic send(input bit big, input logic [7:0] b, input logic stop,
                        input int nbits, output int k0);
        logic [9:0] fr;
        int cpb;
        cpb = big ? 868 : 8;
        fr  = {stop, b, 1'b0};
        k0  = cyc;
        for (int i = 0; i < nbits; i++) begin
            if (big) rx_b = fr[i];
            else     rx_a = fr[i];
            idle(cpb);
        end
    endtask

    task automatic test_reset();
        n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
        n_vec++; if (ifa.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", ifa.valid); end
        n_vec++; if (ifa.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", ifa.frame_err); end
        n_vec++; if (ifa.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", ifa.data_out); end
        n_vec++; if (ifb.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_b: got %b expected 0", ifb.busy); end
    endtask

    task automatic test_single();
        int na, nf, k0;
        na = va_cyc.size(); nf = fa_cyc.size();
        send(0, 8'h55, 1'b1, 10, k0);
        idle(10);
        last_good = 8'h55;
        n_vec++; if (va_cyc.size() !== na + 1) begin n_err++; $display("FAIL single_count: got %0d expected %0d", va_cyc.size(), na + 1); end
        n_vec++; if (va_cyc[na] !== k0 + lat(8)) begin n_err++; $display("FAIL single_time: got %0d expected %0d", va_cyc[na], k0 + lat(8)); end
        n_vec++; if (va_dat[na] !== 8'h55) begin n_err++; $display("FAIL single_data: got %h expected 55", va_dat[na]); end
        n_vec++; if (fa_cyc.size() !== nf) begin n_err++; $display("FAIL single_ferr: got %0d expected %0d", fa_cyc.size(), nf); end
        n_vec++; if (busy_a[k0 + 2] !== 1'b0) begin n_err++; $display("FAIL single_busy2: got %b expected 0", busy_a[k0 + 2]); end
        n_vec++; if (busy_a[k0 + 3] !== 1'b1) begin n_err++; $display("FAIL single_busy3: got %b expected 1", busy_a[k0 + 3]); end
        n_vec++; if (busy_a[k0 + 78] !== 1'b1) begin n_err++; $display("FAIL single_busy78: got %b expected 1", busy_a[k0 + 78]); end
        n_vec++; if (busy_a[k0 + 79] !== 1'b0) begin n_err++; $display("FAIL single_busy79: got %b expected 0", busy_a[k0 + 79]); end
    endtask

    task automatic test_back_to_back();
        int na, k0, k1;
        na = va_cyc.size();
        send(0, 8'hA5, 1'b1, 10, k0);
        send(0, 8'h3C, 1'b1, 10, k1);
        idle(10);
        last_good = 8'h3C;
        n_vec++; if (va_cyc.size() !== na + 2) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", va_cyc.size(), na + 2); end
        n_vec++; if (va_cyc[na] !== k0 + lat(8)) begin n_err++; $display("FAIL b2b_time0: got %0d expected %0d", va_cyc[na], k0 + lat(8)); end
        n_vec++; if (va_cyc[na + 1] - va_cyc[na] !== 80) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 80", va_cyc[na + 1] - va_cyc[na]); end
        n_vec++; if (va_dat[na] !== 8'hA5) begin n_err++; $display("FAIL b2b_data0: got %h expected a5", va_dat[na]); end
        n_vec++; if (va_dat[na + 1] !== 8'h3C) begin n_err++; $display("FAIL b2b_data1: got %h expected 3c", va_dat[na + 1]); end
    endtask

    task automatic test_false_start();
        int na, nf, k0;
        na = va_cyc.size(); nf = fa_cyc.size();
        rx_a = 1'b0;
        idle(3);
        rx_a = 1'b1;
        idle(20);
        n_vec++; if (va_cyc.size() !== na) begin n_err++; $display("FAIL glitch_valid: got %0d expected %0d", va_cyc.size(), na); end
        n_vec++; if (fa_cyc.size() !== nf) begin n_err++; $display("FAIL glitch_ferr: got %0d expected %0d", fa_cyc.size(), nf); end
        n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b expected 0", ifa.busy); end
        n_vec++; if (ifa.data_out !== last_good) begin n_err++; $display("FAIL glitch_data: got %h expected %h", ifa.data_out, last_good); end
        send(0, 8'h81, 1'b1, 10, k0);
        idle(10);
        last_good = 8'h81;
        n_vec++; if (va_dat[na] !== 8'h81) begin n_err++; $display("FAIL glitch_next: got %h expected 81", va_dat[na]); end
        n_vec++; if (va_cyc[na] !== k0 + lat(8)) begin n_err++; $display("FAIL glitch_next_time: got %0d expected %0d", va_cyc[na], k0 + lat(8)); end
    endtask

    task automatic test_frame_err();
        int na, nf, k0, r, k1;
        na = va_cyc.size(); nf = fa_cyc.size();
        send(0, 8'hF0, 1'b0, 10, k0);
        idle(40);
        r = cyc;
        rx_a = 1'b1;
        idle(16);
        n_vec++; if (fa_cyc.size() !== nf + 1) begin n_err++; $display("FAIL ferr_count: got %0d expected %0d", fa_cyc.size(), nf + 1); end
        n_vec++; if (fa_cyc[nf] !== k0 + lat(8)) begin n_err++; $display("FAIL ferr_time: got %0d expected %0d", fa_cyc[nf], k0 + lat(8)); end
        n_vec++; if (va_cyc.size() !== na) begin n_err++; $display("FAIL ferr_valid: got %0d expected %0d", va_cyc.size(), na); end
        n_vec++; if (ifa.data_out !== last_good) begin n_err++; $display("FAIL ferr_data: got %h expected %h", ifa.data_out, last_good); end
        n_vec++; if (busy_a[k0 + 80] !== 1'b1) begin n_err++; $display("FAIL ferr_busy_break: got %b expected 1", busy_a[k0 + 80]); end
        n_vec++; if (busy_a[r + 2] !== 1'b1) begin n_err++; $display("FAIL ferr_busy_hold: got %b expected 1", busy_a[r + 2]); end
        n_vec++; if (busy_a[r + 3] !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release: got %b expected 0", busy_a[r + 3]); end
        send(0, 8'h0F, 1'b1, 10, k1);
        idle(10);
        last_good = 8'h0F;
        n_vec++; if (va_dat[na] !== 8'h0F) begin n_err++; $display("FAIL ferr_next: got %h expected 0f", va_dat[na]); end
    endtask

    task automatic test_reset_mid();
        int na, nf, k0, k1;
        logic [7:0] b;
        b  = 8'($urandom);
        na = va_cyc.size(); nf = fa_cyc.size();
        send(0, b, 1'b1, 5, k0);
        rx_a = b[4];
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        last_good = 8'h00;
        n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", ifa.busy); end
        n_vec++; if (ifa.valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", ifa.valid); end
        n_vec++; if (ifa.data_out !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h expected 00", ifa.data_out); end
        rx_a = 1'b1;
        idle(100);
        n_vec++; if (va_cyc.size() !== na) begin n_err++; $display("FAIL rstmid_nostrobe: got %0d expected %0d", va_cyc.size(), na); end
        n_vec++; if (fa_cyc.size() !== nf) begin n_err++; $display("FAIL rstmid_noferr: got %0d expected %0d", fa_cyc.size(), nf); end
        send(0, 8'hC3, 1'b1, 10, k1);
        idle(10);
        last_good = 8'hC3;
        n_vec++; if (va_dat[na] !== 8'hC3) begin n_err++; $display("FAIL rstmid_next: got %h expected c3", va_dat[na]); end
        n_vec++; if (va_cyc[na] !== k1 + lat(8)) begin n_err++; $display("FAIL rstmid_next_time: got %0d expected %0d", va_cyc[na], k1 + lat(8)); end
    endtask

    task automatic test_random();
        int         na, k, gap;
        int         exp_cyc[$];
        logic [7:0] exp_dat[$];
        logic [7:0] b;
        na = va_cyc.size();
        for (int i = 0; i < 12; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 6);
            if (gap > 0) idle(gap);
            send(0, b, 1'b1, 10, k);
            exp_cyc.push_back(k + lat(8));
            exp_dat.push_back(b);
        end
        idle(10);
        last_good = exp_dat[$];
        n_vec++; if (va_cyc.size() !== na + 12) begin n_err++; $display("FAIL rand_count: got %0d expected %0d", va_cyc.size(), na + 12); end
        for (int i = 0; i < 12; i++) begin
            n_vec++; if (va_dat[na + i] !== exp_dat[i]) begin n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", i, va_dat[na + i], exp_dat[i]); end
            n_vec++; if (va_cyc[na + i] !== exp_cyc[i]) begin n_err++; $display("FAIL rand_time[%0d]: got %0d expected %0d", i, va_cyc[na + i], exp_cyc[i]); end
        end
        n_vec++; if (ifa.data_out !== last_good) begin n_err++; $display("FAIL rand_hold: got %h expected %h", ifa.data_out, last_good); end
    endtask

    task automatic test_slow();
        int nb, k0;
        nb = vb_cyc.size();
        send(1, 8'h6B, 1'b1, 10, k0);
        idle(20);
        n_vec++; if (vb_cyc.size() !== nb + 1) begin n_err++; $display("FAIL slow_count: got %0d expected %0d", vb_cyc.size(), nb + 1); end
        n_vec++; if (vb_cyc[nb] !== k0 + lat(868)) begin n_err++; $display("FAIL slow_time: got %0d expected %0d", vb_cyc[nb], k0 + lat(868)); end
        n_vec++; if (vb_dat[nb] !== 8'h6B) begin n_err++; $display("FAIL slow_data: got %h expected 6b", vb_dat[nb]); end
        n_vec++; if (fb_cnt !== 0) begin n_err++; $display("FAIL slow_ferr: got %0d expected 0", fb_cnt); end
    endtask

    initial begin
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        test_reset();
        rst = 1'b0;
        idle(5);
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_reset_mid();
        test_random();
        test_slow();
        n_vec++; if (both_hi !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d expected 0", both_hi); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
